bridge_pulse_gen: RTL and testbench
===================================

# bridge_pulse_gen

Generates the bipolar excitation drive for the NMR transmit H-bridge: `forward`, `back` and `df` (damping) pulse trains with programmable half-period, dead time, cycle count and damping window. One instance drives each input set (`forward1/back1/df1` or `forward2/back2/df2`) of the downstream bridge-select stage, which picks between two generators. Outputs are registered and glitch-free. `forward` and `back` are never high in the same cycle.

## Interface
Parameters:
- `HP_W`, 16: width of the `half_period` field.
- `DT_W`, 8: width of the `dead_time` field.
- `CNT_W`, 8: width of the `cycles` field.
- `DMP_W`, 16: width of the `damp_len` field.

Ports:
- `clk`  in  1  system clock. One clock domain; every register is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a sequence. Sampled in IDLE only.
- `abort`  in  1  synchronous stop, active high.
- `half_period`  in  HP_W  number of clocks each `forward` or `back` pulse stays high.
- `dead_time`  in  DT_W  number of all-low clocks after each pulse.
- `cycles`  in  CNT_W  number of forward+back pairs.
- `damp_len`  in  DMP_W  number of clocks `df` stays high after the last pair.
- `forward`  out  1  forward bridge drive.
- `back`  out  1  reverse bridge drive.
- `df`  out  1  damping switch drive.
- `busy`  out  1  high while a sequence is running.
- `done`  out  1  one-cycle pulse when a sequence completes normally.
- `err`  out  1  one-cycle pulse when `start` is rejected because of a zero `cycles` or zero `half_period`.

## Operation
- States: IDLE, FWD, DEAD1, BACK, DEAD2, DAMP, FIN.
- IDLE with `start`=1:
  - If `cycles`≠0 and `half_period`≠0: latch all four config fields into shadow registers, load the cycle counter with `cycles`, and go to FWD. Config inputs are don't-care after this point.
  - Otherwise: pulse `err`, stay in IDLE.
- FWD: `forward`=1 for `half_period` clocks, then go to DEAD1.
- DEAD1: all drives low for `dead_time` clocks, then go to BACK. If `dead_time`=0, DEAD1 is skipped and FWD goes directly to BACK.
- BACK: `back`=1 for `half_period` clocks, then go to DEAD2, or skip it when `dead_time`=0.
- DEAD2: all drives low for `dead_time` clocks. At exit, decrement the cycle counter:
  - If the remaining count is not 0, go to FWD.
  - Otherwise go to DAMP, or skip to FIN when `damp_len`=0.
- DAMP: `df`=1 for `damp_len` clocks, then go to FIN.
- FIN: `done`=1 for one clock, then go to IDLE.
- `busy`=1 in every state except IDLE.
- `start` is ignored whenever the state is not IDLE.
- `abort`=1 in any non-IDLE state:
  - Next cycle all drives and `busy` are 0 and the state is IDLE.
  - `done` does not pulse.
  - `abort` has priority over every other transition.
  - `abort` in IDLE has no effect; an `abort` and a `start` in the same IDLE cycle gives a normal start.
- Phase counters are down-counters of the matching field width. Loading `N` gives exactly `N` clocks in the phase. Maximum values, e.g. `half_period`=0xFFFF, must work with no wrap error.
- Invariant: `forward`&`back`=0, and `df` is never high together with `forward` or `back`.

## Timing
- Reset value of every output (`forward`, `back`, `df`, `busy`, `done`, `err`) is 0. The state is IDLE and all counters are 0.
- Reset asserted mid-sequence drops all outputs immediately (asynchronous).
- Latency: `start` sampled at edge k → `forward` and `busy` high from cycle k+1.
- `err` is high in cycle k+1 for a rejected start.
- Total sequence length = `cycles`·2·(`half_period`+`dead_time`) + `damp_len` + 1 (the FIN cycle).
- A new `start` is accepted in the first IDLE cycle after FIN, so back-to-back sequences have a 1-cycle IDLE gap.
- All outputs come directly from flops, so there are no combinational paths from inputs to outputs.

## Test plan
- Nominal: `half_period`=4, `dead_time`=2, `cycles`=2, `damp_len`=3, `start` at cycle 0. Required response:
  - `forward` high in cycles 1–4 and 13–16.
  - `back` high in cycles 7–10 and 19–22.
  - `df` high in cycles 25–27.
  - `done` high in cycle 28.
  - `busy` high in cycles 1–28.
- Zero dead time and zero damping: `half_period`=3, `dead_time`=0, `cycles`=1, `damp_len`=0. Required: `forward` high 1–3, `back` high 4–6, `done` high in cycle 7, `df` never high.
- Reject and ignore:
  - `start` with `cycles`=0 → `err` high in cycle 1, `busy` stays 0.
  - `start` pulsed again during BACK → ignored; the timeline matches the nominal case exactly.
- Abort during FWD (nominal config, `abort` at cycle 3) → all outputs 0 from cycle 4. `done` never pulses. A `start` at cycle 5 restarts normally with `forward` high from cycle 6.
- Reset mid-sequence: assert `rst_n` low during DAMP → `df` and `busy` drop asynchronously. After release, the block is in IDLE and all outputs are 0.
- Invariant checker runs across randomized configs (including maximum field values): `forward`&`back` is never 1, and `df` is never high together with `forward` or `back`.

Source files
------------

// File: rtl/bridge_pulse_gen_if.sv
// Bridge pulse generator bus: request/config from the controller side,
// bridge drives and status back from the generator.
//   master : drives start/abort/config, observes drives and status
//   slave  : the generator itself
interface bridge_pulse_gen_if #(
  parameter int HP_W  = 16,
  parameter int DT_W  = 8,
  parameter int CNT_W = 8,
  parameter int DMP_W = 16
);
  logic             start;
  logic             abort;
  logic [HP_W-1:0]  half_period;
  logic [DT_W-1:0]  dead_time;
  logic [CNT_W-1:0] cycles;
  logic [DMP_W-1:0] damp_len;
  logic             forward;
  logic             back;
  logic             df;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, abort, half_period, dead_time, cycles, damp_len,
    input  forward, back, df, busy, done, err
  );

  modport slave (
    input  start, abort, half_period, dead_time, cycles, damp_len,
    output forward, back, df, busy, done, err
  );
endinterface

// File: rtl/bridge_pulse_gen.sv
// Bipolar H-bridge excitation generator: `cycles` pairs of forward/back
// pulses of `half_period` clocks, each followed by `dead_time` all-low
// clocks, then a `damp_len` clock damping pulse and a one-cycle done.
// Ports:
//   clk   : rising-edge system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bridge_pulse_gen_if (start/abort/config in,
//           forward/back/df/busy/done/err out, all registered)
module bridge_pulse_gen #(
  parameter int HP_W  = 16,
  parameter int DT_W  = 8,
  parameter int CNT_W = 8,
  parameter int DMP_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  bridge_pulse_gen_if.slave  bus
);

  localparam int PW_A = (HP_W > DT_W) ? HP_W : DT_W;
  localparam int PW   = (PW_A > DMP_W) ? PW_A : DMP_W;

  typedef enum logic [2:0] {
    IDLE, FWD, DEAD1, BACK, DEAD2, DAMP, FIN
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic [DT_W-1:0]  dt_q, dt_d;
  logic [DMP_W-1:0] dmp_q, dmp_d;
  logic             err_d;
  logic             pair_end;

  logic forward_q, back_q, df_q, busy_q, done_q, err_q;

  // Phase counter holds (remaining clocks - 1): loading N-1 gives exactly
  // N clocks, and the largest field value never needs a wider register.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cyc_d    = cyc_q;
    hp_d     = hp_q;
    dt_d     = dt_q;
    dmp_d    = dmp_q;
    err_d    = 1'b0;
    pair_end = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.cycles != '0 && bus.half_period != '0) begin
            hp_d    = bus.half_period;
            dt_d    = bus.dead_time;
            dmp_d   = bus.damp_len;
            cyc_d   = bus.cycles;
            cnt_d   = PW'(bus.half_period) - PW'(1);
            state_d = FWD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FWD: begin
        if (cnt_q == '0) begin
          if (dt_q != '0) begin
            cnt_d   = PW'(dt_q) - PW'(1);
            state_d = DEAD1;
          end else begin
            cnt_d   = PW'(hp_q) - PW'(1);
            state_d = BACK;
          end
        end else begin
          cnt_d = cnt_q - PW'(1);
        end
      end
      DEAD1: begin
        if (cnt_q == '0) begin
          cnt_d   = PW'(hp_q) - PW'(1);
          state_d = BACK;
        end else begin
          cnt_d = cnt_q - PW'(1);
        end
      end
      BACK: begin
        if (cnt_q == '0) begin
          if (dt_q != '0) begin
            cnt_d   = PW'(dt_q) - PW'(1);
            state_d = DEAD2;
          end else begin
            pair_end = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - PW'(1);
        end
      end
      DEAD2: begin
        if (cnt_q == '0) pair_end = 1'b1;
        else             cnt_d = cnt_q - PW'(1);
      end
      DAMP: begin
        if (cnt_q == '0) state_d = FIN;
        else             cnt_d = cnt_q - PW'(1);
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // End of a forward+back pair, shared by DEAD2 exit and the
    // zero-dead-time BACK exit.
    if (pair_end) begin
      cyc_d = cyc_q - CNT_W'(1);
      if (cyc_q != CNT_W'(1)) begin
        cnt_d   = PW'(hp_q) - PW'(1);
        state_d = FWD;
      end else if (dmp_q != '0) begin
        cnt_d   = PW'(dmp_q) - PW'(1);
        state_d = DAMP;
      end else begin
        cnt_d   = '0;
        state_d = FIN;
      end
    end

    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      cyc_d   = '0;
    end
  end

  // Outputs are decoded from the next state so they are flops aligned
  // with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cyc_q     <= '0;
      hp_q      <= '0;
      dt_q      <= '0;
      dmp_q     <= '0;
      forward_q <= 1'b0;
      back_q    <= 1'b0;
      df_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cyc_q     <= cyc_d;
      hp_q      <= hp_d;
      dt_q      <= dt_d;
      dmp_q     <= dmp_d;
      forward_q <= (state_d == FWD);
      back_q    <= (state_d == BACK);
      df_q      <= (state_d == DAMP);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == FIN);
      err_q     <= err_d;
    end
  end

  assign bus.forward = forward_q;
  assign bus.back    = back_q;
  assign bus.df      = df_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_bridge_pulse_gen.sv
module tb_bridge_pulse_gen;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  bridge_pulse_gen_if #(.HP_W(16), .DT_W(8), .CNT_W(8), .DMP_W(16)) bus ();

  bridge_pulse_gen #(.HP_W(16), .DT_W(8), .CNT_W(8), .DMP_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int hp, input int dt, input int cy, input int dm);
    bus.half_period = 16'(hp);
    bus.dead_time   = 8'(dt);
    bus.cycles      = 8'(cy);
    bus.damp_len    = 16'(dm);
  endtask

  function automatic bit inr(input int c, input int a, input int b);
    return (c >= a) && (c <= b);
  endfunction

  // {forward, back, df, busy, done, err}
  function automatic logic [5:0] nom(input int c);
    return {inr(c, 1, 4) || inr(c, 13, 16), inr(c, 7, 10) || inr(c, 19, 22),
            inr(c, 25, 27), inr(c, 1, 28), (c == 28), 1'b0};
  endfunction

  function automatic logic [5:0] zd(input int c);
    return {inr(c, 1, 3), inr(c, 4, 6), 1'b0, inr(c, 1, 7), (c == 7), 1'b0};
  endfunction

  function automatic logic [5:0] expf(input int id, input int c);
    logic [5:0] e;
    e = '0;
    case (id)
      0, 3: e = nom(c);
      1, 5: e = zd(c);
      2, 6: e = {5'b0, (c == 1)};
      4: begin
        if (inr(c, 1, 3)) e = 6'b100100;
        else if (c >= 5)  e = nom(c - 5);
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic drive(input int id, input int c);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    case (id)
      0: begin
        if (c == 0) begin set_cfg(4, 2, 2, 3); bus.start = 1'b1; end
        else if (c == 1) set_cfg(0, 0, 0, 0);
      end
      1: if (c == 0) begin set_cfg(3, 0, 1, 0); bus.start = 1'b1; end
      2: if (c == 0) begin set_cfg(4, 2, 0, 3); bus.start = 1'b1; end
      3: begin
        if (c == 0) begin set_cfg(4, 2, 2, 3); bus.start = 1'b1; end
        else if (c == 1) set_cfg(0, 0, 0, 0);
        else if (c == 8) begin set_cfg(9, 9, 9, 9); bus.start = 1'b1; end
      end
      4: begin
        if (c == 0 || c == 5) begin set_cfg(4, 2, 2, 3); bus.start = 1'b1; end
        else if (c == 3) bus.abort = 1'b1;
      end
      5: if (c == 0) begin set_cfg(3, 0, 1, 0); bus.start = 1'b1; bus.abort = 1'b1; end
      6: if (c == 0) begin set_cfg(0, 2, 2, 3); bus.start = 1'b1; end
      default: ;
    endcase
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_test(input int id, input int ncyc);
    logic [5:0] e;
    for (int c = 0; c < ncyc; c++) begin
      drive(id, c);
      @(negedge clk);
      e = expf(id, c);
      chk($sformatf("t%0d_c%0d_forward", id, c), 32'(bus.forward), 32'(e[5]));
      chk($sformatf("t%0d_c%0d_back", id, c),    32'(bus.back),    32'(e[4]));
      chk($sformatf("t%0d_c%0d_df", id, c),      32'(bus.df),      32'(e[3]));
      chk($sformatf("t%0d_c%0d_busy", id, c),    32'(bus.busy),    32'(e[2]));
      chk($sformatf("t%0d_c%0d_done", id, c),    32'(bus.done),    32'(e[1]));
      chk($sformatf("t%0d_c%0d_err", id, c),     32'(bus.err),     32'(e[0]));
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_forward"}, 32'(bus.forward), 0);
    chk({tag, "_back"},    32'(bus.back),    0);
    chk({tag, "_df"},      32'(bus.df),      0);
    chk({tag, "_busy"},    32'(bus.busy),    0);
    chk({tag, "_done"},    32'(bus.done),    0);
    chk({tag, "_err"},     32'(bus.err),     0);
  endtask

  // Whole-sequence check against the length/pulse-count formulas.
  task automatic run_rand(input int hp, input int dt, input int cy, input int dm);
    int len, nbusy, nf, nb, nd, ndone, viol;
    bit ended;
    string tag;
    len = cy * 2 * (hp + dt) + dm + 1;
    nbusy = 0; nf = 0; nb = 0; nd = 0; ndone = 0; viol = 0; ended = 0;
    tag = $sformatf("seq_hp%0d_dt%0d_cy%0d_dm%0d", hp, dt, cy, dm);
    set_cfg(hp, dt, cy, dm);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    set_cfg(0, 0, 0, 0);
    for (int n = 1; n <= len + 10; n++) begin
      @(negedge clk);
      if (!bus.busy) begin ended = 1; break; end
      nbusy++;
      if (bus.forward) nf++;
      if (bus.back)    nb++;
      if (bus.df)      nd++;
      if (bus.done)    ndone++;
      if ((bus.forward && bus.back) || (bus.df && (bus.forward || bus.back))) viol++;
      @(posedge clk); #1;
    end
    if (ended) begin @(posedge clk); #1; end
    chk({tag, "_ended"}, 32'(ended), 1);
    chk({tag, "_len"},   nbusy, len);
    chk({tag, "_fwd"},   nf, cy * hp);
    chk({tag, "_back"},  nb, cy * hp);
    chk({tag, "_df"},    nd, dm);
    chk({tag, "_done"},  ndone, 1);
    chk({tag, "_inv"},   viol, 0);
  endtask

  initial begin
    int nf, nb, nd;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_cfg(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_test(0, 31);  // nominal
    run_test(1, 10);  // zero dead time, zero damping
    run_test(2, 4);   // reject cycles=0
    run_test(6, 4);   // reject half_period=0
    run_test(5, 10);  // abort+start in IDLE starts normally
    run_test(3, 31);  // start during BACK ignored
    run_test(4, 36);  // abort in FWD, then restart

    // Asynchronous reset while damping.
    for (int c = 0; c <= 26; c++) begin
      drive(0, c);
      if (c != 26) begin @(posedge clk); #1; end
    end
    @(negedge clk);
    chk("rst_mid_df_before",   32'(bus.df),   1);
    chk("rst_mid_busy_before", 32'(bus.busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid_async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_mid_after");
    @(posedge clk); #1;
    run_test(1, 10);

    // Randomized configs with invariant and length checks.
    for (int i = 0; i < 8; i++)
      run_rand(int'($urandom_range(1, 6)), int'($urandom_range(0, 3)),
               int'($urandom_range(1, 4)), int'($urandom_range(0, 5)));
    run_rand(1, 0, 255, 0);    // maximum cycles
    run_rand(1, 255, 1, 0);    // maximum dead time
    run_rand(2, 1, 1, 300);

    // Maximum half_period: forward must hold, then abort cleanly.
    set_cfg(16'hFFFF, 8'hFF, 1, 16'hFFFF);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    nf = 0; nb = 0; nd = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.forward) nf++;
      if (bus.back || bus.df) nb++;
      @(posedge clk); #1;
    end
    chk("hpmax_fwd_held", nf, 300);
    chk("hpmax_no_back",  nb, 0);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    chk_all_zero("hpmax_abort");
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus.done || bus.busy) nd++;
    end
    chk("hpmax_no_done_after_abort", nd, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
